// File: rtl/phase_mon_pkg.sv
// Shared types and default sizing for the phase sequence monitor.
// The default modulus matches the team's mod-5 sequencer.
package phase_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } phase_state_t;

  localparam int PHASE_N  = 5;
  localparam int PHASE_PW = 3;

endpackage : phase_mon_pkg

// File: rtl/phase_seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment leaves the count at 1, so that event is not lost.
module sat_counter
  import phase_mon_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_n;

  // next-count selection: clear has priority, increment stops at all-ones
  always_comb begin
    count_n = count_r;
    if (clr) begin
      if (inc) begin
        count_n = W'(1);
      end else begin
        count_n = '0;
      end
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_n = count_r + W'(1);
    end else begin
      count_n = count_r;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_n;
    end
  end

  assign count = count_r;

endmodule : sat_counter

// File: rtl/phase_seq_monitor.sv
// Monitors a mod-N phase counter bus: acquires and locks on legal successions,
// flags illegal/skipped phases, counts errors and wraps, and decodes a one-hot strobe.
module phase_seq_monitor
  import phase_mon_pkg::*;
#(
  parameter int N           = PHASE_N,
  parameter int PW          = PHASE_PW,
  parameter int LOCK_CYCLES = 5,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phase_valid,
  input  logic [PW-1:0]     phase,
  input  logic              clear_err,
  output logic              locked,
  output logic [N-1:0]      phase_onehot,
  output logic              wrap_pulse,
  output logic              err_illegal,
  output logic              err_skip,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int GW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [PW:0]   N_EXT      = (PW + 1)'(N);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);
  localparam logic [GW-1:0] LAST_GOOD  = GW'(LOCK_CYCLES - 1);

  function automatic logic [N-1:0] onehot_of(input logic [PW-1:0] p);
    logic [N-1:0] oh;
    for (int i = 0; i < N; i++) begin
      oh[i] = (p == PW'(i));
    end
    return oh;
  endfunction

  phase_state_t      state_r, state_n;
  logic [PW-1:0]     prev_r, prev_n;
  logic [GW-1:0]     good_r, good_n;
  logic [N-1:0]      onehot_r, onehot_n;
  logic              locked_r;
  logic              wrap_r, wrap_n;
  logic              ill_r, ill_n;
  logic              skip_r, skip_n;
  logic [WRAP_W-1:0] wrap_count_r;
  logic              legal_s;
  logic              succ_s;

  assign legal_s = ({1'b0, phase} < N_EXT);
  assign succ_s  = (prev_r == LAST_PHASE) ? (phase == {PW{1'b0}})
                                          : (phase == prev_r + PW'(1));

  // acquisition/lock FSM: next state, anchor phase, run length and event pulses
  always_comb begin
    state_n  = state_r;
    prev_n   = prev_r;
    good_n   = good_r;
    onehot_n = onehot_r;
    wrap_n   = 1'b0;
    ill_n    = 1'b0;
    skip_n   = 1'b0;
    if (phase_valid) begin
      if (!legal_s) begin
        ill_n    = 1'b1;
        state_n  = IDLE;
        good_n   = '0;
        onehot_n = '0;
      end else begin
        prev_n   = phase;
        onehot_n = onehot_of(phase);
        case (state_r)
          IDLE: begin
            state_n = ACQ;
            good_n  = '0;
          end
          ACQ: begin
            if (succ_s) begin
              if (good_r == LAST_GOOD) begin
                state_n = LOCKED;
                good_n  = '0;
              end else begin
                good_n = good_r + GW'(1);
              end
            end else begin
              good_n = '0;
            end
          end
          LOCKED: begin
            // the wrap that completes lock happens in ACQ, so only LOCKED wraps count
            if (succ_s) begin
              wrap_n = (prev_r == LAST_PHASE);
            end else begin
              skip_n  = 1'b1;
              state_n = ACQ;
              good_n  = '0;
            end
          end
          default: begin
            state_n = IDLE;
            good_n  = '0;
          end
        endcase
      end
    end else begin
      state_n = state_r;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      prev_r       <= '0;
      good_r       <= '0;
      onehot_r     <= '0;
      locked_r     <= 1'b0;
      wrap_r       <= 1'b0;
      ill_r        <= 1'b0;
      skip_r       <= 1'b0;
      wrap_count_r <= '0;
    end else begin
      state_r  <= state_n;
      prev_r   <= prev_n;
      good_r   <= good_n;
      onehot_r <= onehot_n;
      locked_r <= (state_n == LOCKED);
      wrap_r   <= wrap_n;
      ill_r    <= ill_n;
      skip_r   <= skip_n;
      if (wrap_n) begin
        wrap_count_r <= wrap_count_r + WRAP_W'(1);
      end else begin
        wrap_count_r <= wrap_count_r;
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (ill_n | skip_n),
    .clr  (clear_err),
    .count(err_count)
  );

  assign locked       = locked_r;
  assign phase_onehot = onehot_r;
  assign wrap_pulse   = wrap_r;
  assign err_illegal  = ill_r;
  assign err_skip     = skip_r;
  assign wrap_count   = wrap_count_r;

endmodule : phase_seq_monitor

// File: tb/tb_phase_seq_monitor.sv
// Self-checking bench for phase_seq_monitor against a behavioural sequence model.
module tb_phase_seq_monitor;

  localparam int N = 5, PW = 3, LOCK = 5, ERR_W = 8, WRAP_W = 16;

  logic              clk, rst, phase_valid, clear_err;
  logic [PW-1:0]     phase;
  logic              locked, wrap_pulse, err_illegal, err_skip;
  logic [N-1:0]      phase_onehot;
  logic [ERR_W-1:0]  err_count;
  logic [WRAP_W-1:0] wrap_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model: anchored flag, lock flag, run of good steps, last legal phase
  bit           m_anch, m_lock, m_wrap, m_ill, m_skip;
  int           m_prev, m_run, m_err, m_wc;
  logic [N-1:0] m_oh;

  phase_seq_monitor #(
    .N(N), .PW(PW), .LOCK_CYCLES(LOCK), .ERR_W(ERR_W), .WRAP_W(WRAP_W)
  ) dut (
    .clk(clk), .rst(rst), .phase_valid(phase_valid), .phase(phase),
    .clear_err(clear_err), .locked(locked), .phase_onehot(phase_onehot),
    .wrap_pulse(wrap_pulse), .err_illegal(err_illegal), .err_skip(err_skip),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] dut_vec();
    return {locked, phase_onehot, wrap_pulse, err_illegal, err_skip, err_count, wrap_count};
  endfunction

  function automatic logic [32:0] exp_vec();
    return {m_lock, m_oh, m_wrap, m_ill, m_skip, 8'(m_err), 16'(m_wc)};
  endfunction

  task automatic model_reset();
    m_anch = 0; m_lock = 0; m_wrap = 0; m_ill = 0; m_skip = 0;
    m_prev = 0; m_run = 0; m_err = 0; m_wc = 0; m_oh = '0;
  endtask

  // drive one cycle and advance the model; outputs are sampled 1ns after the edge
  task automatic step(input bit v, input int ph, input bit clr);
    phase_valid = v;
    phase       = ph[PW-1:0];
    clear_err   = clr;
    @(posedge clk);
    #1;
    m_wrap = 0; m_ill = 0; m_skip = 0;
    if (v) begin
      if (ph >= N) begin
        m_ill = 1; m_anch = 0; m_lock = 0; m_run = 0; m_oh = '0;
      end else begin
        m_oh = '0;
        m_oh[ph] = 1'b1;
        if (!m_anch) begin
          m_anch = 1; m_run = 0;
        end else if (ph == (m_prev + 1) % N) begin
          if (m_lock) m_wrap = (m_prev == N - 1);
          else begin
            m_run++;
            if (m_run == LOCK) begin m_lock = 1; m_run = 0; end
          end
        end else begin
          if (m_lock) m_skip = 1;
          m_lock = 0; m_run = 0;
        end
        m_prev = ph;
      end
    end
    if (clr) m_err = (m_ill || m_skip) ? 1 : 0;
    else if (m_ill || m_skip) m_err = (m_err == 255) ? 255 : m_err + 1;
    if (m_wrap) m_wc = (m_wc + 1) % 65536;
  endtask

  task automatic test_reset();
    n_vec++;
    if (dut_vec() !== 33'd0) begin
      n_err++; $display("FAIL reset: got %h expected %h", dut_vec(), 33'd0);
    end
  endtask

  task automatic test_lock();
    int seq[11] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 11; i++) begin
      step(1, seq[i], 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL lock[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 4 || i == 5) begin
        n_vec++;
        if (locked !== (i == 5)) begin
          n_err++; $display("FAIL lock_edge[%0d]: got %b expected %b", i, locked, (i == 5));
        end
      end
    end
    n_vec++;
    if ({wrap_pulse, wrap_count, err_count} !== {1'b1, 16'd1, 8'd0}) begin
      n_err++; $display("FAIL first_wrap: got %b/%0d/%0d expected 1/1/0", wrap_pulse, wrap_count, err_count);
    end
  endtask

  task automatic test_skip();
    int seq[12] = '{1, 2, 3, 4, 0, 1, 3, 4, 0, 1, 2, 3};
    for (int i = 0; i < 12; i++) begin
      step(1, seq[i], 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL skip[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 6) begin
        n_vec++;
        if ({err_skip, locked, phase_onehot} !== {1'b1, 1'b0, 5'b01000}) begin
          n_err++; $display("FAIL skip_flag: got %b/%b/%b expected 1/0/01000", err_skip, locked, phase_onehot);
        end
      end
    end
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL relock: got %b expected 1", locked);
    end
  endtask

  task automatic test_illegal();
    int seq[3] = '{6, 2, 3};
    for (int i = 0; i < 3; i++) begin
      step(1, seq[i], 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL illegal[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_gap();
    int ph[10] = '{4, 0, 1, 1, 1, 1, 2, 3, 4, 0};
    bit vl[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      step(vl[i], ph[i], 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL gap[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) step(1, 7, 0);
    n_vec++;
    if (err_count !== 8'd255 || err_count !== 8'(m_err)) begin
      n_err++; $display("FAIL saturate: got %0d expected 255", err_count);
    end
    step(1, 5, 1);
    n_vec++;
    if (err_count !== 8'd1) begin
      n_err++; $display("FAIL clear_with_err: got %0d expected 1", err_count);
    end
    step(0, 0, 1);
    n_vec++;
    if (err_count !== 8'd0) begin
      n_err++; $display("FAIL clear_alone: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) step(1, i % N, 0);
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_lock: got %b expected 1", locked);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (dut_vec() !== 33'd0) begin
      n_err++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 33'd0);
    end
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1, (i + 2) % N, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL relock_after_rst[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int ph, r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 75) ph = (m_prev + 1) % N;
      else if (r < 85) ph = m_prev;
      else ph = $urandom_range(0, 7);
      step($urandom_range(0, 9) < 8, ph, $urandom_range(0, 99) < 3);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; phase_valid = 1'b0; phase = '0; clear_err = 1'b0;
    model_reset();
    #12;
    test_reset();
    rst = 1'b0;
    test_lock();
    test_skip();
    test_illegal();
    test_gap();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_phase_seq_monitor
